// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - single-outstanding load/store port driving a byte-addressed data memory
// Sub-word stores are done as read-modify-write; loads return sign/zero-extended data.
module lsu_mem_port #(
  parameter int TAG_W    = 4,
  parameter int MEM_SIZE = 256
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_store_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic [31:0]      resp_data_o,
  output logic             resp_err_o,
  output logic             mem_wr_en_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  input  logic [31:0]      mem_data_i
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam logic [32:0] ADDR_LIM = 33'(MEM_SIZE);

  state_t            state_q, state_d;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:8]       old_q;
  logic [31:0]       data_q;
  logic [TAG_W-1:0]  tag_q;
  logic              err_q;
  logic              accept;
  logic              f3_ok;
  logic              addr_ok;
  logic              req_ok;
  logic [31:0]       load_ext;

  assign req_ready_o = (state_q == IDLE) && !reset_i;
  assign accept      = req_valid_i && req_ready_o;

  // BU/HU encodings only make sense for loads
  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_store_i;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign addr_ok = (({1'b0, req_addr_i} + 33'd3) < ADDR_LIM);
  assign req_ok  = f3_ok && addr_ok;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!req_ok)                     state_d = RESP;
          else if (!req_store_i)           state_d = LOAD;
          else if (req_funct3_i == 3'b010) state_d = WRITE;
          else                             state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ext = mem_data_i;
    case (f3_q)
      3'b000:  load_ext = {{24{mem_data_i[7]}}, mem_data_i[7:0]};
      3'b001:  load_ext = {{16{mem_data_i[15]}}, mem_data_i[15:0]};
      3'b100:  load_ext = {24'h0, mem_data_i[7:0]};
      3'b101:  load_ext = {16'h0, mem_data_i[15:0]};
      default: load_ext = mem_data_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        tag_q   <= req_tag_i;
        err_q   <= !req_ok;
        data_q  <= '0;
      end
      if (state_q == LOAD)   data_q <= load_ext;
      if (state_q == RMW_RD) old_q  <= mem_data_i[31:8];
    end
  end

  assign resp_valid_o = (state_q == RESP);
  assign resp_tag_o   = tag_q;
  assign resp_data_o  = data_q;
  assign resp_err_o   = err_q;

  // Memory is only addressed while an access is actually in progress
  always_comb begin
    mem_wr_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    case (state_q)
      LOAD, RMW_RD: mem_addr_o = addr_q;
      WRITE: begin
        mem_wr_en_o = 1'b1;
        mem_addr_o  = addr_q;
        case (f3_q)
          3'b000:  mem_data_o = {old_q[31:8], wdata_q[7:0]};
          3'b001:  mem_data_o = {old_q[31:16], wdata_q[15:0]};
          default: mem_data_o = wdata_q;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - scoreboard bench for lsu_mem_port with byte-array memory and reference model
module tb_lsu_mem_port;

  localparam int MEM_SIZE = 256;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_store_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_tag_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [3:0]  resp_tag_o;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  lsu_mem_port #(.TAG_W(4), .MEM_SIZE(MEM_SIZE)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_tag_i(req_tag_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_tag_o(resp_tag_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic [7:0] mem [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];
  exp_t q[$];
  exp_t cur;
  int   tests = 0, fails = 0;
  int   cycle = 0, wr_count = 0, exp_writes = 0;
  int   last_hs = -10, stall_next = 0, stall_left = 0;
  bit   in_resp = 0, have_cur = 0;
  logic [7:0] ma;

  // Memory model: combinational read of current contents, write lands at the edge
  assign ma = mem_addr_o[7:0];
  always_comb begin
    mem_data_i = '0;
    if (mem_addr_o < 32'(MEM_SIZE - 3))
      mem_data_i = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
  end

  always @(posedge clk_i) begin
    cycle <= cycle + 1;
    if (mem_wr_en_o) begin
      wr_count <= wr_count + 1;
      if (mem_addr_o < 32'(MEM_SIZE - 3))
        for (int k = 0; k < 4; k++) mem[ma + 8'(k)] <= mem_data_o[8*k +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    logic [31:0] b0, b1, h;
    b0 = 32'(ref_mem[a]);
    b1 = 32'(ref_mem[a + 1]);
    h  = b0 + 32'd256 * b1;
    case (f3)
      3'b000:  return (b0 >= 128) ? b0 + 32'hFFFFFF00 : b0;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b0;
      3'b101:  return h;
      default: return h + 32'd65536 * 32'(ref_mem[a + 2]) + 32'd16777216 * 32'(ref_mem[a + 3]);
    endcase
  endfunction

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] tg, input bit track);
    int n;
    bit waited, legal;
    exp_t e;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3;
    req_addr_i = a; req_wdata_i = wd; req_tag_i = tg;
    n = 0;
    waited = !req_ready_o;
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      check("req_accept_timeout", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_addr_i = $urandom; req_wdata_i = $urandom; req_tag_i = 4'($urandom);
    if (waited) check("accept_after_handshake", 32'(cycle), 32'(last_hs + 1));
    legal = (longint'(a) + 3 < MEM_SIZE) &&
            (st ? (f3 inside {3'b000, 3'b001, 3'b010}) : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}));
    e.tag = tg; e.err = !legal; e.data = '0; e.acc = cycle;
    if (!legal)                e.lat = 0;
    else if (!st || f3 == 3'b010) e.lat = 1;
    else                       e.lat = 2;
    if (legal && !st) e.data = ref_load(f3, int'(a));
    if (track) begin
      if (legal && st) begin
        exp_writes++;
        ref_mem[a] = wd[7:0];
        if (f3 != 3'b000) ref_mem[a + 1] = wd[15:8];
        if (f3 == 3'b010) begin
          ref_mem[a + 2] = wd[23:16];
          ref_mem[a + 3] = wd[31:24];
        end
      end
      q.push_back(e);
    end
  endtask

  // Response monitor: pops the scoreboard on each new response and drives resp_ready_i
  always @(negedge clk_i) begin
    if (reset_i) begin
      resp_ready_i = 1'b0;
      in_resp = 0;
    end else if (resp_valid_o) begin
      check("busy_req_ready", 32'(req_ready_o), 32'd0);
      if (!in_resp) begin
        in_resp = 1;
        if (q.size() == 0) begin
          have_cur = 0;
          check("spurious_resp", 32'(resp_valid_o), 32'd0);
        end else begin
          cur = q.pop_front();
          have_cur = 1;
          check("resp_tag", 32'(resp_tag_o), 32'(cur.tag));
          check("resp_data", resp_data_o, cur.data);
          check("resp_err", 32'(resp_err_o), 32'(cur.err));
          check("resp_latency", 32'(cycle - cur.acc), 32'(cur.lat));
          stall_left = stall_next;
          stall_next = 0;
        end
      end else if (have_cur) begin
        check("hold_tag", 32'(resp_tag_o), 32'(cur.tag));
        check("hold_data", resp_data_o, cur.data);
        check("hold_err", 32'(resp_err_o), 32'(cur.err));
      end
      if (stall_left > 0) begin
        resp_ready_i = 1'b0;
        stall_left--;
      end else begin
        resp_ready_i = ($urandom_range(0, 3) != 0);
      end
      if (resp_ready_i) last_hs = cycle + 1;
    end else begin
      in_resp = 0;
      resp_ready_i = 1'($urandom_range(0, 1));
      if (q.size() > 0 && cycle > q[0].acc + q[0].lat) begin
        check("resp_missing", 32'(resp_valid_o), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || resp_valid_o || !req_ready_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) check("idle_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  f3;
    logic [7:0]  keep;
    int r, wr_before;
    for (int i = 0; i < MEM_SIZE; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #12;
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_mem_outs", {mem_addr_o[30:0], mem_wr_en_o} | mem_data_o, 32'd0);
    check("rst_resp_outs", resp_data_o | 32'(resp_tag_o) | 32'(resp_err_o), 32'd0);
    #10 reset_i = 1'b0;
    #5;
    check("rel_req_ready", 32'(req_ready_o), 32'd1);
    check("rel_wr_en", 32'(mem_wr_en_o), 32'd0);

    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 4'd3, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 4'd4, 1);
    issue(1, 3'b010, 32'h20, 32'h11223344, 4'd5, 1);
    issue(1, 3'b000, 32'h20, 32'h000000F0, 4'd6, 1);
    issue(0, 3'b000, 32'h20, 32'h0, 4'd7, 1);
    issue(0, 3'b100, 32'h20, 32'h0, 4'd8, 1);
    issue(1, 3'b001, 32'h21, 32'h00008001, 4'd9, 1);
    issue(0, 3'b001, 32'h21, 32'h0, 4'd10, 1);
    issue(0, 3'b101, 32'h21, 32'h0, 4'd11, 1);
    issue(0, 3'b010, 32'd253, 32'h0, 4'd12, 1);
    issue(1, 3'b010, 32'd253, 32'h12345678, 4'd13, 1);
    issue(1, 3'b000, 32'd253, 32'h000000AA, 4'd14, 1);
    issue(0, 3'b011, 32'h10, 32'h0, 4'd15, 1);
    issue(1, 3'b100, 32'h10, 32'h0, 4'd1, 1);
    issue(0, 3'b010, 32'hFFFFFFFF, 32'h0, 4'd2, 1);
    issue(1, 3'b010, 32'd252, 32'hCAFEF00D, 4'd0, 1);
    issue(0, 3'b010, 32'd252, 32'h0, 4'd6, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 4'd2, 1);
    stall_next = 5;
    issue(1, 3'b010, 32'h30, 32'h5A5AA5A5, 4'd3, 1);
    issue(0, 3'b010, 32'h30, 32'h0, 4'd4, 1);
    wait_idle();
    check_mem("mem_after_directed");

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = $urandom_range(250, 255);
      else             a = $urandom_range(0, 252);
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0 && f3 inside {3'b000, 3'b001}) f3 = f3 | 3'b100;
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) stall_next = $urandom_range(3, 7);
      issue(1'($urandom), f3, a, wd, 4'($urandom), 1);
    end
    wait_idle();
    check_mem("mem_after_random");
    check("write_count", 32'(wr_count), 32'(exp_writes));

    keep = ref_mem[8'h40];
    wr_before = wr_count;
    issue(1, 3'b000, 32'h40, {24'h0, ~keep}, 4'd9, 0);
    @(posedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check("abort_wr_en", 32'(mem_wr_en_o), 32'd0);
    check("abort_mem_addr", mem_addr_o, 32'd0);
    check("abort_resp_tag", 32'(resp_tag_o), 32'd0);
    check("abort_resp_valid", 32'(resp_valid_o), 32'd0);
    check("abort_req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #3 reset_i = 1'b0;
    #1;
    check("abort_rel_ready", 32'(req_ready_o), 32'd1);
    repeat (5) @(negedge clk_i);
    check("abort_no_write", 32'(wr_count), 32'(wr_before));
    check("abort_mem_byte", 32'(mem[8'h40]), 32'(keep));
    check_mem("mem_after_abort");
    issue(0, 3'b100, 32'h40, 32'h0, 4'd5, 1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
